// File: rtl/adf4159_reg_writer_if.sv
// Load request and 3-wire SPI bundle between a PLL load sequencer and one ADF4159 writer.
// The request side and the SPI pins share one bundle so a checker can bind to a single instance.
interface adf4159_reg_writer_if;
  // Handshake: load is a level request. It is taken on the first clk edge where the writer is idle.
  // busy rises on that same edge and is the not-ready indication.
  // A load seen while busy is dropped, not queued.
  logic        load;
  logic [11:0] ints;
  logic [24:0] fracs;
  logic        busy;
  logic        spi_clk;
  logic        spi_data;
  logic        spi_le;

  modport master (output load, ints, fracs, input busy, spi_clk, spi_data, spi_le);
  modport slave  (input load, ints, fracs, output busy, spi_clk, spi_data, spi_le);
endinterface

// File: rtl/adf4159_reg_writer.sv
// ADF4159 register writer: latches INT/FRAC on load and shifts R7..R0 (first load) or R1,R0 MSB-first.
// Define ADF4159_FULL_REWRITE_EN to write the full R7..R0 set on every load.
module adf4159_reg_writer #(
  parameter int          CLK_DIV = 2,
  parameter int          LE_GAP  = 4,
  parameter logic [3:0]  R0_MUX  = 4'b0110,
  parameter logic [31:0] R2_VAL  = 32'h0700800A,
  parameter logic [31:0] R3_VAL  = 32'h00430043,
  parameter logic [31:0] R4_VAL  = 32'h00180104,
  parameter logic [31:0] R5_VAL  = 32'h00000005,
  parameter logic [31:0] R6_VAL  = 32'h00000006,
  parameter logic [31:0] R7_VAL  = 32'h00000007
) (
  input  logic                       clk,
  input  logic                       rst,
  adf4159_reg_writer_if.slave        bus,
  output logic [1:0]                 dbg_state
);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(LE_GAP - 1);

  state_t      state;
  logic [11:0] ints_q;
  logic [24:0] fracs_q;
  logic [30:0] shreg;
  logic [2:0]  idx;
  logic [4:0]  bit_cnt;
  logic [15:0] div_cnt;
  logic [2:0]  start_idx;
  logic [31:0] first_word;
  logic [31:0] next_word;
`ifndef ADF4159_FULL_REWRITE_EN
  logic        first_done;
`endif

  // Register index doubles as word selector; the sequence always counts down to R0.
  function automatic logic [31:0] word_of(input logic [2:0] i, input logic [11:0] iv,
                                          input logic [24:0] fv);
    case (i)
      3'd0:    word_of = {1'b0, R0_MUX, iv, fv[24:13], 3'b000};
      3'd1:    word_of = {4'b0000, fv[12:0], 12'h000, 3'b001};
      3'd2:    word_of = R2_VAL;
      3'd3:    word_of = R3_VAL;
      3'd4:    word_of = R4_VAL;
      3'd5:    word_of = R5_VAL;
      3'd6:    word_of = R6_VAL;
      default: word_of = R7_VAL;
    endcase
  endfunction

  always_comb begin
`ifdef ADF4159_FULL_REWRITE_EN
    start_idx = 3'd7;
`else
    start_idx = first_done ? 3'd1 : 3'd7;
`endif
    first_word = word_of(start_idx, bus.ints, bus.fracs);
    next_word  = word_of(idx - 3'd1, ints_q, fracs_q);
  end

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      bus.busy     <= 1'b0;
      bus.spi_clk  <= 1'b0;
      bus.spi_data <= 1'b0;
      bus.spi_le   <= 1'b1;
      ints_q       <= '0;
      fracs_q      <= '0;
      shreg        <= '0;
      idx          <= '0;
      bit_cnt      <= '0;
      div_cnt      <= '0;
`ifndef ADF4159_FULL_REWRITE_EN
      first_done   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.load) begin
            state        <= SETUP;
            bus.busy     <= 1'b1;
            ints_q       <= bus.ints;
            fracs_q      <= bus.fracs;
            idx          <= start_idx;
            shreg        <= first_word[30:0];
            bus.spi_data <= first_word[31];
            bus.spi_le   <= 1'b0;
            div_cnt      <= '0;
          end
        end
        SETUP: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt     <= '0;
            bus.spi_clk <= 1'b1;
            bit_cnt     <= 5'd31;
            state       <= SHIFT;
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        SHIFT: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 16'd1;
          end else begin
            div_cnt <= '0;
            if (bus.spi_clk) begin
              // Falling edge: present the next lower bit while the device is not sampling.
              bus.spi_clk <= 1'b0;
              if (bit_cnt != 5'd0) begin
                bus.spi_data <= shreg[30];
                shreg        <= {shreg[29:0], 1'b0};
              end
            end else if (bit_cnt == 5'd0) begin
              bus.spi_le   <= 1'b1;
              bus.spi_data <= 1'b0;
              state        <= GAP;
            end else begin
              bit_cnt     <= bit_cnt - 5'd1;
              bus.spi_clk <= 1'b1;
            end
          end
        end
        GAP: begin
          if (div_cnt != GAP_LAST) begin
            div_cnt <= div_cnt + 16'd1;
          end else begin
            div_cnt <= '0;
            if (idx == 3'd0) begin
              state    <= IDLE;
              bus.busy <= 1'b0;
`ifndef ADF4159_FULL_REWRITE_EN
              first_done <= 1'b1;
`endif
            end else begin
              idx          <= idx - 3'd1;
              shreg        <= next_word[30:0];
              bus.spi_data <= next_word[31];
              bus.spi_le   <= 1'b0;
              state        <= SETUP;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adf4159_reg_writer.sv
// Directed bench for adf4159_reg_writer: SPI word decoder and timing monitor, expected-word scoreboard.
// Honours ADF4159_FULL_REWRITE_EN for the expected word count of later loads.
module tb_adf4159_reg_writer;
  localparam int CLK_DIV = 2;
  localparam int LE_GAP  = 4;
  localparam int W       = CLK_DIV + 64 * CLK_DIV + LE_GAP;
  localparam logic [31:0] R2 = 32'h0700800A;
  localparam logic [31:0] R3 = 32'h00430043;
  localparam logic [31:0] R4 = 32'h00180104;
  localparam logic [31:0] R5 = 32'h00000005;
  localparam logic [31:0] R6 = 32'h00000006;
  localparam logic [31:0] R7 = 32'h00000007;
`ifdef ADF4159_FULL_REWRITE_EN
  localparam int LATER_WORDS = 8;
`else
  localparam int LATER_WORDS = 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] dbg_state;
  int         checks = 0;
  int         failures = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  adf4159_reg_writer_if bus ();

  adf4159_reg_writer #(
    .CLK_DIV(CLK_DIV), .LE_GAP(LE_GAP), .R0_MUX(4'b0110),
    .R2_VAL(R2), .R3_VAL(R3), .R4_VAL(R4), .R5_VAL(R5), .R6_VAL(R6), .R7_VAL(R7)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_words(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check(tag, (i < got_q.size()) ? got_q[i] : 32'hxxxxxxxx, exp_q[i]);
  endtask

  // SPI monitor: decodes words on rising spi_clk, checks phases, data stability and LE gaps.
  int          mon_bits, mon_run, mon_gap, mon_viol;
  logic [31:0] mon_sh;
  logic        prev_clk, prev_le, held;

  initial begin
    prev_clk = 1'b0; prev_le = 1'b1; held = 1'b0;
    mon_bits = 0; mon_run = 0; mon_gap = 1000; mon_viol = 0; mon_sh = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_clk = 1'b0; prev_le = 1'b1;
        mon_bits = 0; mon_run = 0; mon_gap = 1000; mon_viol = 0;
      end else begin
        if (bus.spi_le && !prev_le) begin
          if (bus.spi_clk || mon_run != CLK_DIV) mon_viol++;
          check("word_bits", mon_bits, 32);
          check("word_timing", mon_viol, 0);
          got_q.push_back(mon_sh);
          mon_gap = 1;
        end else if (bus.spi_le) begin
          mon_gap++;
        end else if (prev_le) begin
          check("le_gap", 32'(mon_gap >= LE_GAP), 32'd1);
          mon_bits = 0; mon_run = 1; mon_sh = '0;
          mon_viol = bus.spi_clk ? 1 : 0;
        end else if (bus.spi_clk == prev_clk) begin
          mon_run++;
          if (bus.spi_clk && bus.spi_data !== held) mon_viol++;
        end else begin
          if (mon_run != CLK_DIV) mon_viol++;
          mon_run = 1;
          if (bus.spi_clk) begin
            mon_sh = {mon_sh[30:0], bus.spi_data};
            held = bus.spi_data;
            mon_bits++;
          end
        end
        prev_clk = bus.spi_clk;
        prev_le  = bus.spi_le;
      end
    end
  end

  // Driver: one load pulse, then scramble inputs and count busy cycles; optional load pulses while busy.
  task automatic run_txn(input logic [11:0] iv, input logic [24:0] fv, input bit pulses,
                         output int cyc);
    @(negedge clk);
    bus.load = 1'b1; bus.ints = iv; bus.fracs = fv;
    @(negedge clk);
    bus.load  = 1'b0;
    bus.ints  = 12'($urandom_range(0, 4095));
    bus.fracs = 25'($urandom_range(0, 33554431));
    cyc = 0;
    while (bus.busy && cyc < 20000) begin
      cyc++;
      bus.load = (pulses && (cyc % 50 == 10)) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    bus.load = 1'b0;
  endtask

  int cyc, rises, low, exp_rises;
  bit fell, prev_b;

  initial begin
    bus.load = 1'b0; bus.ints = '0; bus.fracs = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_spi_clk", bus.spi_clk, 0);
    check("rst_spi_data", bus.spi_data, 0);
    check("rst_spi_le", bus.spi_le, 1);
    check("rst_state", dbg_state, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // First load after reset: full set
    got_q.delete();
    run_txn(12'd44, 25'd31407723, 1'b0, cyc);
    check("busy_first", cyc, 8 * W);
    exp_q = '{R7, R6, R5, R4, R3, R2, 32'h0F358001, 32'h301677C8};
    check_words("words_first");

    // Second load with pulses while busy: no extra words
    got_q.delete();
    run_txn(12'd98, 25'd9702969, 1'b1, cyc);
    check("busy_second", cyc, LATER_WORDS * W);
    repeat (20) @(negedge clk);
    check("idle_after_pulses", bus.busy, 0);
`ifdef ADF4159_FULL_REWRITE_EN
    exp_q = '{R7, R6, R5, R4, R3, R2, 32'h071C8001, 32'h30312500};
`else
    exp_q = '{32'h071C8001, 32'h30312500};
`endif
    check_words("words_second");

    // Load held high: back-to-back transactions with a single idle cycle between them
    got_q.delete();
    bus.ints = 12'd98; bus.fracs = 25'd9702969;
    rises = 0; low = 0; fell = 1'b0; prev_b = 1'b0;
    bus.load = 1'b1;
    for (int i = 1; i <= 3000; i++) begin
      @(negedge clk);
      if (bus.busy && !prev_b) begin
        rises++;
        if (fell) check("idle_gap", low, 1);
        low = 0;
      end else if (!bus.busy) begin
        if (prev_b) fell = 1'b1;
        low++;
      end
      prev_b = bus.busy;
    end
    bus.load = 1'b0;
    cyc = 0;
    while (bus.busy && cyc < 20000) begin
      cyc++;
      @(negedge clk);
    end
    check("held_drain", 32'(cyc < 20000), 32'd1);
    exp_rises = (3000 - 1) / (LATER_WORDS * W + 1) + 1;
    check("held_txns", rises, exp_rises);
    check("held_words", got_q.size(), LATER_WORDS * exp_rises);

    // Reset in the middle of word 3 at bit 17
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    got_q.delete();
    bus.ints = 12'd44; bus.fracs = 25'd31407723; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    cyc = 0;
    while (!(got_q.size() == 2 && mon_bits == 15) && cyc < 5000) begin
      cyc++;
      @(negedge clk);
    end
    check("reach_bit17", 32'(cyc < 5000), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("abort_spi_le", bus.spi_le, 1);
    check("abort_spi_clk", bus.spi_clk, 0);
    check("abort_busy", bus.busy, 0);
    repeat (2) @(negedge clk);
    check("abort_no_partial", got_q.size(), 2);
    rst = 1'b1;
    @(negedge clk);
    got_q.delete();
    run_txn(12'd44, 25'd31407723, 1'b0, cyc);
    check("busy_restart", cyc, 8 * W);
    exp_q = '{R7, R6, R5, R4, R3, R2, 32'h0F358001, 32'h301677C8};
    check_words("words_restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
